cpu_ctrl_vic: RTL

- Parametrised next-generation CPU control block: owns control registers, the pipeline stall/flush network and interrupt arbitration.
- Adds to the previous generation: IRQ_CH channels, per-channel edge/level mode, a pending register, fixed-priority vectored interrupts, and a nested-exception state stack.
- Sits beside decode and the MEM/WB register; decode turns int_detect into an external-interrupt exception code.

---
 rtl/cpu_ctrl_vic.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_ctrl_vic.sv
// cpu_ctrl_vic: CPU control block with vectored interrupt controller.
//   Owns the control registers, the pipeline stall/flush network, interrupt
//   pending/mask/edge-mode state and a small saved-context stack for nested
//   exceptions.
// Ports:
//   clk, reset                      clock, async active-high reset
//   creg_rd_addr / creg_rd_data     combinational control register read
//   exe_mode                        1 = kernel, 0 = user
//   irq / int_detect                raw requests in, unmasked pending out
//   id_pc, mem_pc                   word PCs of ID and MEM stages
//   mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_exp_code, mem_out
//                                   MEM-stage instruction info
//   if_busy, mem_busy, ld_hazard    pipeline status in
//   *_stall, *_flush, new_pc        pipeline control out
// Commit rule: the MEM instruction takes effect on the clock edge where
// mem_en=1 and no stall is present; flush/new_pc are combinational and stay
// asserted for as long as the instruction waits in MEM.
module cpu_ctrl_vic #(
  parameter int         IRQ_CH      = 8,
  parameter int         STACK_DEPTH = 2,
  parameter int         VEC_SHIFT   = 2,
  parameter logic [2:0] EXP_EXT_INT = 3'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        creg_rd_addr,
  output logic [31:0]       creg_rd_data,
  output logic              exe_mode,
  input  logic [IRQ_CH-1:0] irq,
  output logic              int_detect,
  input  logic [29:0]       id_pc,
  input  logic [29:0]       mem_pc,
  input  logic              mem_en,
  input  logic              mem_br_flag,
  input  logic [1:0]        mem_ctrl_op,
  input  logic [4:0]        mem_dst_addr,
  input  logic [2:0]        mem_exp_code,
  input  logic [31:0]       mem_out,
  input  logic              if_busy,
  input  logic              mem_busy,
  input  logic              ld_hazard,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              mem_stall,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              mem_flush,
  output logic [29:0]       new_pc
);
  localparam logic [1:0] OP_WRCR  = 2'd1;
  localparam logic [1:0] OP_EXRT  = 2'd2;
  localparam logic [2:0] DEPTH_C  = 3'(STACK_DEPTH);
  localparam logic [1:0] FULL_TOP = 2'(STACK_DEPTH - 1);

  // Stack entry layout: [31] exe_mode, [30] int_en, [29:0] epc (word).
  // Storage is sized for the maximum depth; only STACK_DEPTH entries are used.
  logic [31:0]       stk_q [4];
  logic [31:0]       stk_d [4];
  logic [2:0]        cnt_q, cnt_d;
  logic              exe_mode_q, exe_mode_d, int_en_q, int_en_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic [29:0]       exp_vector_q, exp_vector_d;
  logic [2:0]        exp_code_q, exp_code_d;
  logic              dly_flag_q, dly_flag_d;
  logic [3:0]        irq_id_q, irq_id_d;
  logic [IRQ_CH-1:0] mask_q, mask_d, edge_mode_q, edge_mode_d;
  logic [IRQ_CH-1:0] pend_q, pend_d, irq_q;
  logic [29:0]       pre_pc_q, pre_pc_d;
  logic              br_flag_q, br_flag_d;

  logic              stall, commit, is_exc, is_exrt, is_wrcr, is_ext;
  logic [1:0]        top_idx;
  logic [31:0]       top_entry;
  logic [IRQ_CH-1:0] pending, req, sel_oh, pend_clr;
  logic [3:0]        irq_sel;
  logic              flush;

  assign stall   = if_busy | mem_busy;
  assign commit  = mem_en & ~stall;
  assign is_exc  = mem_en & (mem_exp_code != 3'd0);
  assign is_exrt = mem_en & ~is_exc & (mem_ctrl_op == OP_EXRT);
  assign is_wrcr = mem_en & ~is_exc & (mem_ctrl_op == OP_WRCR);
  assign is_ext  = mem_exp_code == EXP_EXT_INT;

  assign top_idx   = (cnt_q == 3'd0) ? 2'd0 : 2'(cnt_q - 3'd1);
  assign top_entry = stk_q[top_idx];

  // Level channels read the live request; edge channels read the latch.
  assign pending    = (pend_q & edge_mode_q) | (irq & ~edge_mode_q);
  assign req        = pending & ~mask_q;
  assign int_detect = int_en_q & (|req);
  assign exe_mode   = exe_mode_q;

  // Lowest-index unmasked pending channel wins.
  always_comb begin
    irq_sel = 4'd0;
    sel_oh  = '0;
    for (int i = IRQ_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        irq_sel   = 4'(i);
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    flush  = 1'b0;
    new_pc = 30'd0;
    if (is_exc) begin
      flush  = 1'b1;
      new_pc = exp_vector_q + (is_ext ? (30'(irq_sel) << VEC_SHIFT) : 30'd0);
    end else if (is_exrt) begin
      flush  = 1'b1;
      new_pc = (cnt_q == 3'd0) ? 30'd0 : top_entry[29:0];
    end else if (is_wrcr) begin
      flush  = 1'b1;
      new_pc = mem_pc;
    end
  end

  assign if_stall  = stall | ld_hazard;
  assign id_stall  = stall;
  assign ex_stall  = stall;
  assign mem_stall = stall;
  assign if_flush  = flush;
  assign id_flush  = flush | ld_hazard;
  assign ex_flush  = flush;
  assign mem_flush = flush;

  always_comb begin
    creg_rd_data = 32'd0;
    case (creg_rd_addr)
      5'd0: creg_rd_data = {28'd0, ovf_q, unf_q, int_en_q, exe_mode_q};
      5'd1: creg_rd_data = {30'd0, top_entry[30], top_entry[31]};
      5'd2: creg_rd_data = {id_pc, 2'b00};
      5'd3: creg_rd_data = {top_entry[29:0], 2'b00};
      5'd4: creg_rd_data = {exp_vector_q, 2'b00};
      5'd5: creg_rd_data = {20'd0, irq_id_q, 4'd0, dly_flag_q, exp_code_q};
      5'd6: creg_rd_data = 32'(mask_q);
      5'd7: creg_rd_data = 32'(pending);
      5'd8: creg_rd_data = 32'(edge_mode_q);
      5'd9: creg_rd_data = 32'(cnt_q);
      default: creg_rd_data = 32'd0;
    endcase
  end

  always_comb begin
    stk_d        = stk_q;
    cnt_d        = cnt_q;
    exe_mode_d   = exe_mode_q;
    int_en_d     = int_en_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    exp_vector_d = exp_vector_q;
    exp_code_d   = exp_code_q;
    dly_flag_d   = dly_flag_q;
    irq_id_d     = irq_id_q;
    mask_d       = mask_q;
    edge_mode_d  = edge_mode_q;
    pre_pc_d     = pre_pc_q;
    br_flag_d    = br_flag_q;
    pend_clr     = '0;
    if (commit) begin
      pre_pc_d  = mem_pc;
      br_flag_d = mem_br_flag;
      if (is_exc) begin
        // A full stack loses its newest context rather than blocking.
        if (cnt_q == DEPTH_C) begin
          stk_d[FULL_TOP] = {exe_mode_q, int_en_q, pre_pc_q};
          ovf_d           = 1'b1;
        end else begin
          stk_d[cnt_q[1:0]] = {exe_mode_q, int_en_q, pre_pc_q};
          cnt_d             = cnt_q + 3'd1;
        end
        exe_mode_d = 1'b1;
        int_en_d   = 1'b0;
        exp_code_d = mem_exp_code;
        dly_flag_d = br_flag_q;
        if (is_ext) begin
          irq_id_d = irq_sel;
          pend_clr = sel_oh;
        end
      end else if (is_exrt) begin
        if (cnt_q == 3'd0) begin
          exe_mode_d = 1'b1;
          int_en_d   = 1'b0;
          unf_d      = 1'b1;
        end else begin
          exe_mode_d = top_entry[31];
          int_en_d   = top_entry[30];
          cnt_d      = cnt_q - 3'd1;
        end
      end else if (is_wrcr) begin
        case (mem_dst_addr)
          5'd0: begin
            exe_mode_d = mem_out[0];
            int_en_d   = mem_out[1];
            unf_d      = mem_out[2];
            ovf_d      = mem_out[3];
          end
          5'd1: stk_d[top_idx][31:30] = {mem_out[0], mem_out[1]};
          5'd3: stk_d[top_idx][29:0]  = mem_out[31:2];
          5'd4: exp_vector_d = mem_out[31:2];
          5'd5: begin
            irq_id_d   = mem_out[11:8];
            dly_flag_d = mem_out[3];
            exp_code_d = mem_out[2:0];
          end
          5'd6: mask_d      = mem_out[IRQ_CH-1:0];
          5'd7: pend_clr    = mem_out[IRQ_CH-1:0];
          5'd8: edge_mode_d = mem_out[IRQ_CH-1:0];
          default: ;
        endcase
      end
    end
    // Rising edges are applied after clears so a coincident set wins.
    pend_d = ((pend_q & ~pend_clr) | (irq & ~irq_q)) & edge_mode_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) stk_q[i] <= 32'd0;
      cnt_q        <= 3'd0;
      exe_mode_q   <= 1'b1;
      int_en_q     <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      exp_vector_q <= 30'd0;
      exp_code_q   <= 3'd0;
      dly_flag_q   <= 1'b0;
      irq_id_q     <= 4'd0;
      mask_q       <= '1;
      edge_mode_q  <= '0;
      pend_q       <= '0;
      irq_q        <= '0;
      pre_pc_q     <= 30'd0;
      br_flag_q    <= 1'b0;
    end else begin
      stk_q        <= stk_d;
      cnt_q        <= cnt_d;
      exe_mode_q   <= exe_mode_d;
      int_en_q     <= int_en_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      exp_vector_q <= exp_vector_d;
      exp_code_q   <= exp_code_d;
      dly_flag_q   <= dly_flag_d;
      irq_id_q     <= irq_id_d;
      mask_q       <= mask_d;
      edge_mode_q  <= edge_mode_d;
      pend_q       <= pend_d;
      irq_q        <= irq;
      pre_pc_q     <= pre_pc_d;
      br_flag_q    <= br_flag_d;
    end
  end
endmodule
